// File: rtl/lb_slave_decoder_if.sv
// lb_slave_decoder_if: upstream LB request/ack, downstream slave strobes/acks and error status
interface lb_slave_decoder_if #(
  parameter int NUM_SLV = 3,
  parameter int ADR_W = 32,
  parameter int DAT_W = 32
);
  logic lb_wreq, lb_rreq, lb_wack, lb_rack;
  logic [ADR_W-1:0] lb_wadr, lb_radr, s_adr, err_adr;
  logic [DAT_W-1:0] lb_wdat, lb_rdat, s_wdat;
  logic [NUM_SLV-1:0] s_wreq, s_rreq, s_wack, s_rack;
  logic [NUM_SLV*DAT_W-1:0] s_rdat;
  logic err_flag, proto_err, err_clr;
  modport slave (
    input lb_wreq, lb_wadr, lb_wdat, lb_rreq, lb_radr, s_wack, s_rack, s_rdat, err_clr,
    output lb_wack, lb_rack, lb_rdat, s_wreq, s_rreq, s_adr, s_wdat, err_flag, err_adr, proto_err
  );
  modport master (
    output lb_wreq, lb_wadr, lb_wdat, lb_rreq, lb_radr, s_wack, s_rack, s_rdat, err_clr,
    input lb_wack, lb_rack, lb_rdat, s_wreq, s_rreq, s_adr, s_wdat, err_flag, err_adr, proto_err
  );
endinterface

// File: rtl/lb_slave_decoder.sv
// lb_slave_decoder: routes LB accesses to register slaves by address field, turning unmapped/unanswered ones into error acks
module lb_slave_decoder #(
  parameter int NUM_SLV = 3,
  parameter int ADR_W = 32,
  parameter int DAT_W = 32,
  parameter int SEL_LSB = 16,
  parameter int SEL_W = 2,
  parameter int TMO_CYC = 256,
  parameter logic [DAT_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input logic clk,
  input logic rst_n,
  lb_slave_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic dir_w, pend;
  logic [SEL_W-1:0] sel, go_sel;
  logic [ADR_W-1:0] pend_adr, go_adr, fin_adr;
  logic [15:0] cnt;
  logic [NUM_SLV-1:0] hot, go_hot;
  logic [DAT_W-1:0] rdat_sel;
  logic go, go_w, go_map, ack, tmo, fin, fin_w, fin_err, stray;
  // a new access starts from IDLE, or from RESP when a read was parked behind a simultaneous write
  assign go = (state == IDLE && (bus.lb_wreq || bus.lb_rreq)) || (state == RESP && pend);
  assign go_w = state == IDLE && bus.lb_wreq;
  assign go_adr = state == RESP ? pend_adr : go_w ? bus.lb_wadr : bus.lb_radr;
  assign go_sel = go_adr[SEL_LSB +: SEL_W];
  assign go_map = int'(go_sel) < NUM_SLV;
  assign go_hot = NUM_SLV'(1) << go_sel;
  assign hot = NUM_SLV'(1) << sel;
  assign ack = state == WAIT && |(hot & (dir_w ? bus.s_wack : bus.s_rack));
  assign tmo = state == WAIT && !ack && cnt == 16'(TMO_CYC - 1);
  assign fin = (go && !go_map) || ack || tmo;
  assign fin_w = go ? go_w : dir_w;
  assign fin_err = (go && !go_map) || tmo;
  assign fin_adr = go ? go_adr : bus.s_adr;
  assign stray = state != IDLE && (bus.lb_wreq || bus.lb_rreq);
  // read data slice of the currently selected slave
  always_comb begin
    rdat_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) if (hot[i]) rdat_sel = bus.s_rdat[i*DAT_W +: DAT_W];
  end
  // sequencer: one outstanding access, strobe, wait for ack or timeout, ack upstream, track errors
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dir_w <= 1'b0;
      pend <= 1'b0;
      sel <= '0;
      pend_adr <= '0;
      cnt <= '0;
      bus.lb_wack <= 1'b0;
      bus.lb_rack <= 1'b0;
      bus.lb_rdat <= '0;
      bus.s_wreq <= '0;
      bus.s_rreq <= '0;
      bus.s_adr <= '0;
      bus.s_wdat <= '0;
      bus.err_flag <= 1'b0;
      bus.err_adr <= '0;
      bus.proto_err <= 1'b0;
    end else begin
      state <= fin ? RESP : go ? ISSUE : state == ISSUE ? WAIT : state == RESP ? IDLE : state;
      cnt <= state == WAIT ? cnt + 16'd1 : '0;
      bus.s_wreq <= go && go_map && go_w ? go_hot : '0;
      bus.s_rreq <= go && go_map && !go_w ? go_hot : '0;
      bus.lb_wack <= fin && fin_w;
      bus.lb_rack <= fin && !fin_w;
      if (fin && !fin_w) bus.lb_rdat <= fin_err ? ERR_DATA : rdat_sel;
      if (go) begin
        dir_w <= go_w;
        sel <= go_sel;
        pend <= go_w && bus.lb_rreq;
        bus.s_adr <= go_adr;
      end
      if (go_w) begin
        bus.s_wdat <= bus.lb_wdat;
        pend_adr <= bus.lb_radr;
      end
      if (bus.err_clr) begin
        bus.err_flag <= 1'b0;
        bus.err_adr <= '0;
        bus.proto_err <= 1'b0;
      end else begin
        if (fin && fin_err) bus.err_flag <= 1'b1;
        if (fin && fin_err && !bus.err_flag) bus.err_adr <= fin_adr;
        if (stray) bus.proto_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_lb_slave_decoder.sv
// tb_lb_slave_decoder: directed and random LB accesses against a latency/error model of the decoder
module tb_lb_slave_decoder;
  localparam int TMO = 256;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 0, rst_n = 1;
  int n_chk = 0, n_fail = 0;
  bit m_flag = 0, m_proto = 0;
  logic [31:0] m_adr = 0;
  lb_slave_decoder_if #(.NUM_SLV(3), .ADR_W(32), .DAT_W(32)) bus ();
  lb_slave_decoder #(.TMO_CYC(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".err_flag"}, bus.err_flag, m_flag);
    chk({tag, ".err_adr"}, bus.err_adr, m_adr);
    chk({tag, ".proto_err"}, bus.proto_err, m_proto);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ctl"}, {bus.lb_wack, bus.lb_rack, bus.s_wreq, bus.s_rreq, bus.err_flag, bus.proto_err}, 0);
    chk({tag, ".dat"}, |{bus.lb_rdat, bus.s_adr, bus.s_wdat, bus.err_adr}, 0);
  endtask

  task automatic model_err(input logic [31:0] adr);
    if (!m_flag) m_adr = adr;
    m_flag = 1;
  endtask

  task automatic clear_err();
    @(negedge clk);
    bus.err_clr = 1;
    @(negedge clk);
    bus.err_clr = 0;
    m_flag = 0;
    m_proto = 0;
    m_adr = 0;
    chk_status("clr");
  endtask

  // dly: cycles from strobe to the selected slave's ack (<1 = never); stray: cycle of an extra read request (0 = none)
  task automatic access(input bit w, input logic [31:0] adr, input logic [31:0] dat, input logic [31:0] sdat,
                        input int dly, input int stray);
    int sel = int'(adr[17:16]);
    bit map = sel < 3;
    bit ok = map && dly >= 1 && dly <= TMO;
    int exp_c = !map ? 1 : ok ? dly + 2 : TMO + 2;
    logic [2:0] own = map ? 3'(1 << sel) : 3'b0;
    int last = ((dly + 1 > exp_c) ? dly + 1 : exp_c) + 2;
    int ack_c = -1, stb_c = -1, n_ack = 0, n_stb = 0;
    logic [2:0] stb_v = '0;
    @(negedge clk);
    if (w) begin
      bus.lb_wreq = 1;
      bus.lb_wadr = adr;
      bus.lb_wdat = dat;
    end else begin
      bus.lb_rreq = 1;
      bus.lb_radr = adr;
    end
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      bus.lb_wreq = 0;
      bus.lb_rreq = 0;
      if (c == stray) begin
        bus.lb_rreq = 1;
        bus.lb_radr = $urandom;
      end
      if (|bus.s_wreq || |bus.s_rreq) begin
        n_stb++;
        stb_c = c;
        stb_v = bus.s_wreq | bus.s_rreq;
        chk("stb_dir", bus.s_wreq != 0, w);
        chk("s_adr", bus.s_adr, adr);
        if (w) chk("s_wdat", bus.s_wdat, dat);
      end
      if (bus.lb_wack || bus.lb_rack) begin
        n_ack++;
        if (ack_c < 0) begin
          ack_c = c;
          chk("ack_dir", bus.lb_wack, w);
          if (!w) chk("lb_rdat", bus.lb_rdat, ok ? sdat : ERR);
        end
      end
      bus.s_wack = 3'($urandom) & ~(w ? own : 3'b0);
      bus.s_rack = 3'($urandom) & ~(w ? 3'b0 : own);
      bus.s_rdat = {$urandom, $urandom, $urandom};
      if (map && c == dly + 1) begin
        if (w) bus.s_wack |= own;
        else bus.s_rack |= own;
        bus.s_rdat[sel*32 +: 32] = sdat;
      end
    end
    bus.s_wack = 0;
    bus.s_rack = 0;
    chk("n_ack", n_ack, 1);
    chk("ack_cycle", ack_c, exp_c);
    chk("n_stb", n_stb, map);
    chk("stb_vec", stb_v, own);
    if (map) chk("stb_cycle", stb_c, 1);
    if (!ok) model_err(adr);
    if (stray > 0) m_proto = 1;
    chk_status("acc");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int ws_c, rs_c, wa_c, ra_c, n_ack, s, d, ec;
    logic [2:0] wv, rv;
    logic [31:0] a, sd;
    bus.lb_wreq = 0; bus.lb_rreq = 0; bus.lb_wadr = 0; bus.lb_radr = 0; bus.lb_wdat = 0;
    bus.s_wack = 0; bus.s_rack = 0; bus.s_rdat = 0; bus.err_clr = 0;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    access(1, 32'h0002_0010, 32'h1234_5678, 32'h0, 2, 0);
    access(0, 32'h0001_0004, 32'h0, 32'hCAFE_0001, 1, 0);
    access(0, 32'h0000_0100, 32'h0, 32'h1111_2222, 299, 0);
    access(0, 32'h0001_0200, 32'h0, 32'h3333_4444, TMO, 0);
    access(1, 32'h0002_0300, 32'h5555_6666, 32'h0, TMO + 1, 0);
    clear_err();
    access(1, 32'h0003_0000, 32'h7777_8888, 32'h0, 1, 0);
    access(0, 32'h0003_0044, 32'h0, 32'h0, 1, 0);
    access(0, 32'h0000_0008, 32'h0, 32'h9999_AAAA, 3, 3);
    clear_err();
    // error set and clear in the same cycle: clear wins
    access(1, 32'h0003_0010, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    bus.lb_wreq = 1; bus.lb_wadr = 32'h0003_0040; bus.err_clr = 1;
    @(negedge clk);
    bus.lb_wreq = 0; bus.err_clr = 0;
    chk("clrprio.wack", bus.lb_wack, 1);
    m_flag = 0; m_proto = 0; m_adr = 0;
    chk_status("clrprio");
    // simultaneous write (slave1) and read (slave2)
    sd = $urandom;
    @(negedge clk);
    bus.lb_wreq = 1; bus.lb_wadr = 32'h0001_0020; bus.lb_wdat = 32'hA5A5_0F0F;
    bus.lb_rreq = 1; bus.lb_radr = 32'h0002_0040;
    ws_c = -1; rs_c = -1; wa_c = -1; ra_c = -1; wv = 0; rv = 0; n_ack = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.lb_wreq = 0; bus.lb_rreq = 0; bus.s_wack = 0; bus.s_rack = 0;
      if (|bus.s_wreq) begin ws_c = c; wv = bus.s_wreq; chk("sim.w_adr", bus.s_adr, 32'h0001_0020); end
      if (|bus.s_rreq) begin rs_c = c; rv = bus.s_rreq; chk("sim.r_adr", bus.s_adr, 32'h0002_0040); end
      if (bus.lb_wack) begin wa_c = c; n_ack++; end
      if (bus.lb_rack) begin ra_c = c; n_ack++; chk("sim.rdat", bus.lb_rdat, sd); end
      if (ws_c > 0 && c == ws_c + 2) bus.s_wack = 3'b010;
      if (rs_c > 0 && c == rs_c + 2) begin bus.s_rack = 3'b100; bus.s_rdat[64 +: 32] = sd; end
    end
    bus.s_wack = 0; bus.s_rack = 0;
    chk("sim.wstb", {ws_c[7:0], 5'b0, wv}, {8'd1, 5'b0, 3'b010});
    chk("sim.wack", wa_c, 4);
    chk("sim.rstb", {rs_c[7:0], 5'b0, rv}, {8'd5, 5'b0, 3'b100});
    chk("sim.rack", ra_c, 8);
    chk("sim.n_ack", n_ack, 2);
    chk_status("sim");
    // reset while waiting on a silent slave
    @(negedge clk);
    bus.lb_rreq = 1; bus.lb_radr = 32'h0000_0300;
    repeat (4) @(negedge clk) bus.lb_rreq = 0;
    rst_n = 0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst_n = 1;
    m_flag = 0; m_proto = 0; m_adr = 0;
    n_ack = 0;
    for (int c = 0; c < TMO + 20; c++) begin
      @(negedge clk);
      if (bus.lb_wack || bus.lb_rack || |bus.s_wreq || |bus.s_rreq) n_ack++;
    end
    chk("midrst.quiet", n_ack, 0);
    chk_status("midrst");
    access(0, 32'h0000_0304, 32'h0, 32'hBEEF_0304, 2, 0);
    // random accesses
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      s = $urandom_range(0, 3);
      d = $urandom_range(1, 6);
      a[17:16] = 2'(s);
      ec = s < 3 ? d + 2 : 1;
      access($urandom_range(0, 1) == 1, a, $urandom, $urandom, d,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ec)) : 0);
      if (i % 8 == 7) clear_err();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
